// File: rtl/mem_arbiter.sv
// Shares one single-port big-endian RAM between the fetch and load/store ports.
// It uses alternating-priority arbitration and turns byte stores into a read-modify-write pair.
module mem_arbiter #(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_byte,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic [31:0] ram_ad,
    output logic [31:0] ram_d,
    output logic        ram_we,
    input  logic [31:0] ram_q
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RMW  = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    logic            owner_d;
    logic            last_d;
    logic [AW-1:0]   lat_addr;
    logic [BW-1:0]   lat_wdata;
    logic            lat_we;
    logic            lat_byte;
    logic            grant_if;
    logic            grant_d;

    // Arbitration, next state and RAM/requester outputs for the current cycle.
    // RAM-side outputs are combinational so the address is presented in the issue cycle.
    always_comb begin
        next_state = state;
        grant_if   = 1'b0;
        grant_d    = 1'b0;
        ram_ad     = '0;
        ram_d      = '0;
        ram_we     = 1'b0;
        if_valid   = 1'b0;
        if_rdata   = '0;
        d_valid    = 1'b0;
        d_rdata    = '0;

        unique case (state)
            IDLE: begin
                if (if_req && d_req) begin
                    grant_d  = ~last_d;
                    grant_if = last_d;
                end else begin
                    grant_d  = d_req;
                    grant_if = if_req;
                end
                if (grant_d) begin
                    ram_ad = d_addr;
                    if (d_we && !d_byte) begin
                        ram_we = 1'b1;
                        ram_d  = d_wdata;
                    end
                    next_state = (d_we && d_byte) ? RMW : ACK;
                end else if (grant_if) begin
                    ram_ad     = if_addr;
                    next_state = ACK;
                end
            end
            RMW: begin
                ram_ad     = lat_addr;
                ram_we     = 1'b1;
                ram_d      = {lat_wdata, ram_q[DW-BW-1:0]};
                next_state = ACK;
            end
            ACK: begin
                ram_ad = lat_addr;
                if (owner_d) begin
                    d_valid = 1'b1;
                    if (!lat_we) begin
                        d_rdata = lat_byte ? {(DW-BW)'(0), ram_q[DW-1:DW-BW]} : ram_q;
                    end
                end else begin
                    if_valid = 1'b1;
                    if_rdata = ram_q;
                end
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase

        // Reset silences every output, including a write already in progress.
        if (rst) begin
            ram_ad   = '0;
            ram_d    = '0;
            ram_we   = 1'b0;
            if_valid = 1'b0;
            if_rdata = '0;
            d_valid  = 1'b0;
            d_rdata  = '0;
        end
    end

    // State register plus the transaction latched at grant time.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner_d   <= 1'b0;
            last_d    <= ~DATA_FIRST;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            lat_byte  <= 1'b0;
        end else begin
            state <= next_state;
            if (grant_d) begin
                owner_d   <= 1'b1;
                last_d    <= 1'b1;
                lat_addr  <= d_addr;
                lat_wdata <= d_wdata[BW-1:0];
                lat_we    <= d_we;
                lat_byte  <= d_byte;
            end else if (grant_if) begin
                owner_d   <= 1'b0;
                last_d    <= 1'b0;
                lat_addr  <= if_addr;
                lat_wdata <= '0;
                lat_we    <= 1'b0;
                lat_byte  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-addressed big-endian RAM model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req;
    logic        d_we;
    logic        d_byte;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic [31:0] ram_ad;
    logic [31:0] ram_d;
    logic        ram_we;
    logic [31:0] ram_q;
    logic        load_mem;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [0:255];

    mem_arbiter #(.DATA_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid),
        .ram_ad(ram_ad), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            32'h20:  return 8'h11;
            32'h21:  return 8'h22;
            32'h22:  return 8'h33;
            32'h23:  return 8'h44;
            32'h24:  return 8'h00;
            default: return 8'(i) ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [31:0] init_word(input int a);
        return {init_byte(a), init_byte(a + 1), init_byte(a + 2), init_byte(a + 3)};
    endfunction

    // RAM model: registered read of four bytes at A..A+3, whole-word write.
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
        end else begin
            ram_q <= {mem[ram_ad[7:0]], mem[8'(ram_ad[7:0] + 8'd1)],
                      mem[8'(ram_ad[7:0] + 8'd2)], mem[8'(ram_ad[7:0] + 8'd3)]};
            if (ram_we) begin
                mem[ram_ad[7:0]]               <= ram_d[31:24];
                mem[8'(ram_ad[7:0] + 8'd1)]    <= ram_d[23:16];
                mem[8'(ram_ad[7:0] + 8'd2)]    <= ram_d[15:8];
                mem[8'(ram_ad[7:0] + 8'd3)]    <= ram_d[7:0];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle;
        @(negedge clk);
        #1;
    endtask

    // Presents a data request at the start of an IDLE cycle and samples the issue cycle.
    task automatic issue_d(input logic we, input logic byt, input logic [31:0] addr,
                           input logic [31:0] wdata);
        @(negedge clk);
        d_req   = 1'b1;
        d_we    = we;
        d_byte  = byt;
        d_addr  = addr;
        d_wdata = wdata;
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ram_we"}, 32'(ram_we), 32'd0);
        check({tag, "_ram_ad"}, ram_ad, 32'd0);
        check({tag, "_valids"}, {30'd0, if_valid, d_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; load_mem = 1'b1;
        if_req = 1'b1; if_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_byte = 1'b0; d_addr = 32'h44; d_wdata = 32'h0;

        // Reset with both requests held: every output stays zero.
        repeat (2) begin
            next_cycle();
            check("rst_ram_we", 32'(ram_we), 32'd0);
            check("rst_ram_ad", ram_ad, 32'd0);
            check("rst_ram_d", ram_d, 32'd0);
            check("rst_valids", {30'd0, if_valid, d_valid}, 32'd0);
            check("rst_rdata", if_rdata | d_rdata, 32'd0);
        end

        // Contention: D first, then strict alternation, one valid every 2 cycles.
        @(negedge clk);
        rst = 1'b0; load_mem = 1'b0;
        #1;
        for (int t = 0; t < 6; t++) begin
            check("cont_issue_ad", ram_ad, (t % 2 == 0) ? 32'h44 : 32'h40);
            check("cont_issue_we", 32'(ram_we), 32'd0);
            check("cont_issue_valids", {30'd0, if_valid, d_valid}, 32'd0);
            next_cycle();
            check("cont_ack_valids", {30'd0, if_valid, d_valid},
                  (t % 2 == 0) ? 32'd1 : 32'd2);
            check("cont_ack_if_rdata", if_rdata, (t % 2 == 0) ? 32'd0 : init_word(32'h40));
            check("cont_ack_d_rdata", d_rdata, (t % 2 == 0) ? init_word(32'h44) : 32'd0);
            check("cont_ack_we", 32'(ram_we), 32'd0);
            if (t < 5) next_cycle();
        end
        if_req = 1'b0; d_req = 1'b0;
        next_cycle();
        check_idle("idle_after_cont");

        // Word store then word load.
        issue_d(1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
        check("sw_issue_we", 32'(ram_we), 32'd1);
        check("sw_issue_ad", ram_ad, 32'h10);
        check("sw_issue_d", ram_d, 32'hDEADBEEF);
        check("sw_issue_valid", 32'(d_valid), 32'd0);
        next_cycle();
        check("sw_ack_valid", 32'(d_valid), 32'd1);
        check("sw_ack_we", 32'(ram_we), 32'd0);
        check("sw_ack_rdata", d_rdata, 32'd0);
        check("sw_ack_ram_d", ram_d, 32'd0);
        d_req = 1'b0;
        issue_d(1'b0, 1'b0, 32'h10, 32'h0);
        check("lw_issue_ad", ram_ad, 32'h10);
        check("lw_issue_we", 32'(ram_we), 32'd0);
        next_cycle();
        check("lw_ack_valid", 32'(d_valid), 32'd1);
        check("lw_ack_rdata", d_rdata, 32'hDEADBEEF);
        d_req = 1'b0;
        next_cycle();
        check("lw_after_valid", 32'(d_valid), 32'd0);
        check("lw_after_rdata", d_rdata, 32'd0);

        // Byte store as read-modify-write.
        issue_d(1'b1, 1'b1, 32'h21, 32'hFFFFFFA5);
        check("sb_issue_we", 32'(ram_we), 32'd0);
        check("sb_issue_ad", ram_ad, 32'h21);
        next_cycle();
        check("sb_rmw_we", 32'(ram_we), 32'd1);
        check("sb_rmw_ad", ram_ad, 32'h21);
        check("sb_rmw_d", ram_d, 32'hA5334400);
        check("sb_rmw_valid", 32'(d_valid), 32'd0);
        next_cycle();
        check("sb_ack_valid", 32'(d_valid), 32'd1);
        check("sb_ack_we", 32'(ram_we), 32'd0);
        check("sb_ack_rdata", d_rdata, 32'd0);
        d_req = 1'b0;

        issue_d(1'b0, 1'b0, 32'h20, 32'h0);
        next_cycle();
        check("sb_verify_valid", 32'(d_valid), 32'd1);
        check("sb_verify_word", d_rdata, 32'h11A53344);
        d_req = 1'b0;

        // Byte loads are zero-extended.
        issue_d(1'b0, 1'b1, 32'h22, 32'h0);
        next_cycle();
        check("lb22_valid", 32'(d_valid), 32'd1);
        check("lb22_rdata", d_rdata, 32'h00000033);
        d_req = 1'b0;
        issue_d(1'b0, 1'b1, 32'h21, 32'h0);
        next_cycle();
        check("lb21_rdata", d_rdata, 32'h000000A5);
        d_req = 1'b0;

        // Reset during the RMW write cycle abandons the byte store.
        issue_d(1'b1, 1'b1, 32'h30, 32'h00000077);
        check("rr_issue_we", 32'(ram_we), 32'd0);
        @(negedge clk);
        rst = 1'b1; d_req = 1'b0;
        #1;
        check("rr_rmw_we", 32'(ram_we), 32'd0);
        check("rr_rmw_valid", 32'(d_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle("rr_after");
        issue_d(1'b0, 1'b0, 32'h30, 32'h0);
        next_cycle();
        check("rr_verify_valid", 32'(d_valid), 32'd1);
        check("rr_verify_word", d_rdata, init_word(32'h30));
        d_req = 1'b0;

        // Single fetch after reset uses the fetch port alone.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h50;
        #1;
        check("if_issue_ad", ram_ad, 32'h50);
        next_cycle();
        check("if_ack_valid", {30'd0, if_valid, d_valid}, 32'd2);
        check("if_ack_rdata", if_rdata, init_word(32'h50));
        if_req = 1'b0;
        next_cycle();
        check_idle("if_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
